greensc_ctrl: RTL
=================

Name: greensc_ctrl

Overview:
Frame-synchronous controller for the green-screen keyer stage.
- Owns the keyer enable, the hue key window [hue_lo, hue_hi] and the animated background phase offset.
- Commits all changes on frame boundaries (vsync) only, so the keyer never switches mid-frame.
- Provides one-shot auto-calibration: measures the mean hue of a centre sample window over one full frame and recentres the key window on it.

Parameters:
WIN_ROW0, 208, first row of the calibration sample window
WIN_COL0, 288, first column of the calibration sample window
WIN_LOG2, 6, sample window is 2^WIN_LOG2 square (64x64 = 4096 pixels)
DEF_CENTER, 120, reset key hue centre, in degrees
DEF_HALFW, 30, reset key half-width, in degrees
HALFW_MIN, 5, minimum half-width
HALFW_MAX, 90, maximum half-width
HALFW_STEP, 5, half-width change per width_up/width_dn pulse
PHASE_STEP, 1, background phase advance per frame, in degrees

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
vsync  in  1  one-cycle pulse at the start of each frame
pix_valid  in  1  row, col and hue_in are valid this cycle
row  in  14  current pixel row
col  in  14  current pixel column
hue_in  in  9  pixel hue, 0..359
key_en_sw  in  1  user enable level for the keyer
cal_req  in  1  pulse: request calibration
width_up  in  1  pulse: widen the key window
width_dn  in  1  pulse: narrow the key window
gsc_en  out  1  keyer enable to the datapath
hue_lo  out  9  active lower key bound
hue_hi  out  9  active upper key bound
bg_phase  out  9  background hue offset, 0..359
cal_busy  out  1  high from acceptance of cal_req until the result is applied
cal_done  out  1  one-cycle pulse: calibration succeeded
cal_fail  out  1  one-cycle pulse: calibration found no samples

Behaviour:
Reset values:
- gsc_en=0, bg_phase=0, cal_busy=0, cal_done=0, cal_fail=0.
- Shadow and active centre = DEF_CENTER; shadow and active half-width = DEF_HALFW.
- hue_lo = DEF_CENTER-DEF_HALFW, hue_hi = DEF_CENTER+DEF_HALFW.
- FSM = IDLE, accumulator and sample counter cleared.
- Reset asserted mid-calibration aborts it; no done/fail pulse is issued.

Shadow registers (centre, half-width, enable):
- Update at any cycle.
- width_up: halfw = min(halfw+HALFW_STEP, HALFW_MAX).
- width_dn: halfw = max(halfw-HALFW_STEP, HALFW_MIN).
- width_up and width_dn in the same cycle: no change.
- key_en_sw is sampled into the shadow enable every cycle.

Frame commit:
- In the vsync cycle, shadow values are copied into the active registers; outputs change on the next clock edge (1-cycle latency).
- hue_lo = max(centre-halfw, 0); hue_hi = min(centre+halfw, 359). Use signed 10-bit intermediate arithmetic.
- bg_phase += PHASE_STEP at each vsync while the active enable is 1, wrapping modulo 360 (359+1 -> 0). It holds while disabled.
- gsc_en = active enable AND NOT cal_frame. cal_frame is high for the frame being sampled, so the camera hue is measured unkeyed.

Calibration FSM:
- IDLE: cal_req -> ARM, cal_busy=1. cal_req while busy is ignored. cal_req coincident with vsync still goes to ARM; that vsync does not start sampling.
- ARM: on vsync -> ACCUM; clear sum (21 bits) and count (13 bits); set cal_frame=1 at the commit.
- ACCUM: accumulate hue_in into sum and increment count on each cycle where all hold:
  - pix_valid=1
  - WIN_ROW0 <= row < WIN_ROW0+2^WIN_LOG2
  - WIN_COL0 <= col < WIN_COL0+2^WIN_LOG2
  - hue_in <= 359 (values above 359 are ignored)
  On vsync -> EVAL; cal_frame clears at that commit.
- EVAL, one cycle:
  - count==0: pulse cal_fail; shadow unchanged.
  - count==full window: shadow centre = sum >> (2*WIN_LOG2).
  - Partial count: centre = sum / count via a sequential restoring divider of 21 cycles, held in EVAL.
  Then -> APPLY.
- APPLY: pulse cal_done (unless failed), cal_busy=0 -> IDLE. The new centre reaches the outputs at the next vsync commit.
- Hue wrap-around at 0/360 is not handled; the mean is arithmetic.
- width_up/width_dn during calibration still act on the shadow half-width.

Test Plan:
- Reset, then vsync -> hue_lo=90, hue_hi=150, gsc_en=0, bg_phase=0.
- key_en_sw=1, 3 vsyncs -> gsc_en=1 one cycle after the first vsync; bg_phase 1,2 after the 2nd/3rd; preload bg_phase=359 plus vsync -> 0.
- 20 width_up pulses then vsync -> halfw clamps at 90: hue_lo=30, hue_hi=210. width_up+width_dn in the same cycle -> unchanged.
- cal_req, full 640x480 frame with hue_in=100 in the window and 300 elsewhere -> gsc_en=0 during the sampled frame, cal_done pulses, next vsync gives hue_lo=70, hue_hi=130, gsc_en restored.
- cal_req with pix_valid never high in the window -> cal_fail pulses, bounds unchanged. Half-window (2048 samples at hue 50) -> centre 50 via divider path: hue_lo=20, hue_hi=80.
- rst asserted during ACCUM -> FSM IDLE, cal_busy=0, no done/fail pulse, defaults restored.

Source files
------------

// File: rtl/greensc_ctrl_if.sv
// Control/status bundle between the frame timing, the user controls and
// the green-screen keyer controller.
interface greensc_ctrl_if;
   logic        vsync;
   logic        pix_valid;
   logic [13:0] row;
   logic [13:0] col;
   logic [8:0]  hue_in;
   logic        key_en_sw;
   logic        cal_req;
   logic        width_up;
   logic        width_dn;
   logic        gsc_en;
   logic [8:0]  hue_lo;
   logic [8:0]  hue_hi;
   logic [8:0]  bg_phase;
   logic        cal_busy;
   logic        cal_done;
   logic        cal_fail;

   modport master (
      output vsync, pix_valid, row, col, hue_in,
      output key_en_sw, cal_req, width_up, width_dn,
      input  gsc_en, hue_lo, hue_hi, bg_phase,
      input  cal_busy, cal_done, cal_fail
   );

   modport slave (
      input  vsync, pix_valid, row, col, hue_in,
      input  key_en_sw, cal_req, width_up, width_dn,
      output gsc_en, hue_lo, hue_hi, bg_phase,
      output cal_busy, cal_done, cal_fail
   );
endinterface

// File: rtl/greensc_ctrl.sv
// Frame-synchronous green-screen keyer controller: shadow/active key window,
// animated background phase and one-shot hue auto-calibration.
module greensc_ctrl #(
   parameter int WIN_ROW0   = 208,
   parameter int WIN_COL0   = 288,
   parameter int WIN_LOG2   = 6,
   parameter int DEF_CENTER = 120,
   parameter int DEF_HALFW  = 30,
   parameter int HALFW_MIN  = 5,
   parameter int HALFW_MAX  = 90,
   parameter int HALFW_STEP = 5,
   parameter int PHASE_STEP = 1
) (
   input  logic           clk,
   input  logic           rst,
   greensc_ctrl_if.slave  bus
);

   localparam logic [13:0] ROW_LO    = 14'(WIN_ROW0);
   localparam logic [13:0] ROW_HI    = 14'(WIN_ROW0 + (1 << WIN_LOG2));
   localparam logic [13:0] COL_LO    = 14'(WIN_COL0);
   localparam logic [13:0] COL_HI    = 14'(WIN_COL0 + (1 << WIN_LOG2));
   localparam logic [12:0] FULL_CNT  = 13'(1 << (2 * WIN_LOG2));
   localparam int          SUM_SHIFT = 2 * WIN_LOG2;
   localparam logic [4:0]  DIV_LAST  = 5'd20;

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_ACCUM, S_EVAL, S_APPLY} state_t;

   state_t      state_q, state_d;
   logic [8:0]  sh_center_q, sh_center_d;
   logic [6:0]  sh_halfw_q, sh_halfw_d;
   logic        sh_en_q, sh_en_d;
   logic [8:0]  act_center_q, act_center_d;
   logic [6:0]  act_halfw_q, act_halfw_d;
   logic        act_en_q, act_en_d;
   logic        cal_frame_q, cal_frame_d;
   logic [8:0]  phase_q, phase_d;
   logic [20:0] sum_q, sum_d;
   logic [12:0] cnt_q, cnt_d;
   logic [12:0] rem_q, rem_d;
   logic [4:0]  div_cnt_q, div_cnt_d;

   logic        in_win;
   logic [13:0] div_rs;
   logic        div_ge;
   logic [12:0] div_rem_nxt;
   logic [20:0] div_quo_nxt;

   function automatic logic [8:0] calc_lo(input logic [8:0] c, input logic [6:0] h);
      logic signed [9:0] v;
      v = signed'({1'b0, c}) - signed'({3'b000, h});
      if (v < 0) v = '0;
      return 9'(v);
   endfunction

   function automatic logic [8:0] calc_hi(input logic [8:0] c, input logic [6:0] h);
      logic signed [9:0] v;
      v = signed'({1'b0, c}) + signed'({3'b000, h});
      if (v > 10'sd359) v = 10'sd359;
      return 9'(v);
   endfunction

   function automatic logic [6:0] halfw_inc(input logic [6:0] h);
      logic [7:0] t;
      t = {1'b0, h} + 8'(HALFW_STEP);
      if (t > 8'(HALFW_MAX)) t = 8'(HALFW_MAX);
      return 7'(t);
   endfunction

   function automatic logic [6:0] halfw_dec(input logic [6:0] h);
      if ({1'b0, h} < 8'(HALFW_MIN + HALFW_STEP)) return 7'(HALFW_MIN);
      return h - 7'(HALFW_STEP);
   endfunction

   function automatic logic [8:0] phase_adv(input logic [8:0] p);
      logic [9:0] t;
      t = {1'b0, p} + 10'(PHASE_STEP);
      if (t >= 10'd360) t = t - 10'd360;
      return 9'(t);
   endfunction

   // Sample qualifier for the calibration window; out-of-range hues are dropped.
   assign in_win = bus.pix_valid &&
                   (bus.row >= ROW_LO) && (bus.row < ROW_HI) &&
                   (bus.col >= COL_LO) && (bus.col < COL_HI) &&
                   (bus.hue_in <= 9'd359);

   // One restoring-division step: sum_q shifts the dividend out and the quotient in.
   assign div_rs      = {rem_q, sum_q[20]};
   assign div_ge      = (div_rs >= {1'b0, cnt_q});
   assign div_rem_nxt = div_ge ? 13'(div_rs - {1'b0, cnt_q}) : div_rs[12:0];
   assign div_quo_nxt = {sum_q[19:0], div_ge};

   // Next-state logic: shadow updates, frame commit and calibration FSM.
   always_comb begin
      state_d      = state_q;
      sh_center_d  = sh_center_q;
      sh_halfw_d   = sh_halfw_q;
      sh_en_d      = bus.key_en_sw;
      act_center_d = act_center_q;
      act_halfw_d  = act_halfw_q;
      act_en_d     = act_en_q;
      cal_frame_d  = cal_frame_q;
      phase_d      = phase_q;
      sum_d        = sum_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      div_cnt_d    = div_cnt_q;

      if (bus.width_up && !bus.width_dn) sh_halfw_d = halfw_inc(sh_halfw_q);
      else if (bus.width_dn && !bus.width_up) sh_halfw_d = halfw_dec(sh_halfw_q);

      if (bus.vsync) begin
         act_center_d = sh_center_q;
         act_halfw_d  = sh_halfw_q;
         act_en_d     = sh_en_q;
         if (act_en_q) phase_d = phase_adv(phase_q);
      end

      case (state_q)
         S_IDLE: begin
            if (bus.cal_req) state_d = S_ARM;
         end
         S_ARM: begin
            if (bus.vsync) begin
               state_d     = S_ACCUM;
               sum_d       = '0;
               cnt_d       = '0;
               rem_d       = '0;
               div_cnt_d   = '0;
               cal_frame_d = 1'b1;
            end
         end
         S_ACCUM: begin
            if (in_win) begin
               sum_d = sum_q + {12'd0, bus.hue_in};
               cnt_d = cnt_q + 13'd1;
            end
            if (bus.vsync) begin
               state_d     = S_EVAL;
               cal_frame_d = 1'b0;
            end
         end
         S_EVAL: begin
            if (cnt_q == '0) begin
               state_d = S_APPLY;
            end else if (cnt_q == FULL_CNT) begin
               sh_center_d = 9'(sum_q >> SUM_SHIFT);
               state_d     = S_APPLY;
            end else begin
               sum_d     = div_quo_nxt;
               rem_d     = div_rem_nxt;
               div_cnt_d = div_cnt_q + 5'd1;
               if (div_cnt_q == DIV_LAST) begin
                  sh_center_d = div_quo_nxt[8:0];
                  state_d     = S_APPLY;
               end
            end
         end
         S_APPLY: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset to the default key setup.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sh_center_q  <= 9'(DEF_CENTER);
         sh_halfw_q   <= 7'(DEF_HALFW);
         sh_en_q      <= 1'b0;
         act_center_q <= 9'(DEF_CENTER);
         act_halfw_q  <= 7'(DEF_HALFW);
         act_en_q     <= 1'b0;
         cal_frame_q  <= 1'b0;
         phase_q      <= '0;
         sum_q        <= '0;
         cnt_q        <= '0;
         rem_q        <= '0;
         div_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         sh_center_q  <= sh_center_d;
         sh_halfw_q   <= sh_halfw_d;
         sh_en_q      <= sh_en_d;
         act_center_q <= act_center_d;
         act_halfw_q  <= act_halfw_d;
         act_en_q     <= act_en_d;
         cal_frame_q  <= cal_frame_d;
         phase_q      <= phase_d;
         sum_q        <= sum_d;
         cnt_q        <= cnt_d;
         rem_q        <= rem_d;
         div_cnt_q    <= div_cnt_d;
      end
   end

   assign bus.gsc_en   = act_en_q & ~cal_frame_q;
   assign bus.hue_lo   = calc_lo(act_center_q, act_halfw_q);
   assign bus.hue_hi   = calc_hi(act_center_q, act_halfw_q);
   assign bus.bg_phase = phase_q;
   assign bus.cal_busy = (state_q != S_IDLE);
   assign bus.cal_fail = (state_q == S_EVAL) && (cnt_q == '0);
   assign bus.cal_done = (state_q == S_APPLY) && (cnt_q != '0);

endmodule
